// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM states and
// bit positions of the registered result flags.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOT  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_ADC  = 4'd8;
   localparam logic [3:0] OP_SBB  = 4'd9;
   localparam logic [3:0] OP_ROL  = 4'd10;
   localparam logic [3:0] OP_ROR  = 4'd11;
   localparam logic [3:0] OP_SRA  = 4'd12;
   localparam logic [3:0] OP_MUL  = 4'd13;
   localparam logic [3:0] OP_CMP  = 4'd14;
   localparam logic [3:0] OP_RSVD = 4'd15;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   localparam int FLAG_CARRY   = 0;
   localparam int FLAG_ZERO    = 1;
   localparam int FLAG_OVF     = 2;
   localparam int FLAG_ILLEGAL = 3;
   localparam int NUM_FLAGS    = 4;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one multiplier bit per cycle, the final
// partial sum is presented combinationally alongside done.
module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      count;

   assign acc_next = mplier[0] ? (acc + mcand) : acc;
   assign done     = busy && (count == CW'(1));
   assign product  = acc_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         count  <= CW'(WIDTH);
      end else if (busy) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count - CW'(1);
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides, a carry flag
// chained between operations and a multi-cycle multiply.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int OP_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             carry,
   output logic             zero,
   output logic             neg,
   output logic             ovf,
   output logic             illegal
);

   state_t state_q, state_d;

   logic                 cf;
   logic [NUM_FLAGS-1:0] flags;
   logic                 accept;
   logic                 mul_start;
   logic                 mul_busy;
   logic                 mul_done;
   logic [2*WIDTH-1:0]   mul_product;

   logic [WIDTH:0]       sum;
   logic [WIDTH:0]       diff;
   logic                 add_cin;
   logic                 sub_bin;
   logic                 add_ovf;
   logic                 sub_ovf;
   logic [WIDTH-1:0]     res_y;
   logic [NUM_FLAGS-1:0] res_flags;
   logic                 res_cmp;
   logic                 cf_load;

   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (op == OP_MUL);

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = !mul_busy && (!out_valid || out_ready);
            if (mul_start) state_d = ST_MUL;
         end
         ST_MUL: begin
            if (mul_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Both arithmetic paths run one bit wider so bit WIDTH is carry or borrow.
   always_comb begin
      add_cin = (op == OP_ADC) ? cf : 1'b0;
      sub_bin = (op == OP_SBB) ? cf : 1'b0;
      sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
      diff    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_bin};
      add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
   end

   always_comb begin
      res_y     = '0;
      res_flags = '0;
      res_cmp   = 1'b0;
      cf_load   = 1'b1;
      case (op)
         OP_ADD, OP_ADC: begin
            res_y                = sum[WIDTH-1:0];
            res_flags[FLAG_CARRY] = sum[WIDTH];
            res_flags[FLAG_OVF]   = add_ovf;
         end
         OP_SUB, OP_SBB: begin
            res_y                = diff[WIDTH-1:0];
            res_flags[FLAG_CARRY] = diff[WIDTH];
            res_flags[FLAG_OVF]   = sub_ovf;
         end
         OP_CMP: begin
            res_y                = a;
            res_cmp              = 1'b1;
            res_flags[FLAG_CARRY] = diff[WIDTH];
            res_flags[FLAG_OVF]   = sub_ovf;
         end
         OP_AND: begin res_y = a & b; cf_load = 1'b0; end
         OP_OR:  begin res_y = a | b; cf_load = 1'b0; end
         OP_XOR: begin res_y = a ^ b; cf_load = 1'b0; end
         OP_NOT: begin res_y = ~a;    cf_load = 1'b0; end
         OP_SHL: begin
            res_y                = {a[WIDTH-2:0], 1'b0};
            res_flags[FLAG_CARRY] = a[WIDTH-1];
         end
         OP_SHR: begin
            res_y                = {1'b0, a[WIDTH-1:1]};
            res_flags[FLAG_CARRY] = a[0];
         end
         OP_ROL: begin
            res_y                = {a[WIDTH-2:0], a[WIDTH-1]};
            res_flags[FLAG_CARRY] = a[WIDTH-1];
         end
         OP_ROR: begin
            res_y                = {a[0], a[WIDTH-1:1]};
            res_flags[FLAG_CARRY] = a[0];
         end
         OP_SRA: begin
            res_y                = {a[WIDTH-1], a[WIDTH-1:1]};
            res_flags[FLAG_CARRY] = a[0];
         end
         OP_MUL: cf_load = 1'b0;
         default: begin
            res_flags[FLAG_ILLEGAL] = 1'b1;
            cf_load                 = 1'b0;
         end
      endcase
      res_flags[FLAG_ZERO] = res_cmp ? (diff[WIDTH-1:0] == '0) : (res_y == '0);
   end

   // A MUL accept empties the output stage; accept is only possible when
   // the previous result is absent or being consumed this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         y         <= '0;
         flags     <= NUM_FLAGS'(1 << FLAG_ZERO);
         cf        <= 1'b0;
      end else if (state_q == ST_MUL && mul_done) begin
         out_valid                <= 1'b1;
         y                        <= mul_product[WIDTH-1:0];
         flags                    <= '0;
         flags[FLAG_CARRY]        <= |mul_product[2*WIDTH-1:WIDTH];
         flags[FLAG_ZERO]         <= (mul_product[WIDTH-1:0] == '0);
         cf                       <= |mul_product[2*WIDTH-1:WIDTH];
      end else if (mul_start) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         y         <= res_y;
         flags     <= res_flags;
         if (cf_load) cf <= res_flags[FLAG_CARRY];
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign carry   = flags[FLAG_CARRY];
   assign zero    = flags[FLAG_ZERO];
   assign ovf     = flags[FLAG_OVF];
   assign illegal = flags[FLAG_ILLEGAL];
   assign neg     = y[WIDTH-1];

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors push expected results,
// a negedge monitor pops and compares each consumed result.
module tb_alu_seq;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [3:0] op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] y;
   logic       carry;
   logic       zero;
   logic       neg;
   logic       ovf;
   logic       illegal;

   typedef struct {
      string      name;
      logic [7:0] y;
      logic       c;
      logic       z;
      logic       n;
      logic       v;
      logic       il;
   } exp_t;

   exp_t sb[$];
   int   n_compared;
   int   n_mismatched;

   alu_seq #(.WIDTH(8), .OP_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .carry     (carry),
      .zero      (zero),
      .neg       (neg),
      .ovf       (ovf),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_compared++;
      if (act !== req) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
      end
   endtask

   // Drives one operation, waits (bounded) for the handshake and queues its expected result.
   task automatic applyStimulus(input string nm, input logic [3:0] o,
                                input logic [7:0] av, input logic [7:0] bv,
                                input logic [7:0] ey, input logic ec, input logic ez,
                                input logic en, input logic ev, input logic eil);
      exp_t e;
      bit   ok;
      in_valid = 1'b1;
      op       = o;
      a        = av;
      b        = bv;
      ok       = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checkOutput({nm, "_accept_timeout"}, 32'd0, 32'd1);
      end else begin
         e.name = nm; e.y = ey; e.c = ec; e.z = ez; e.n = en; e.v = ev; e.il = eil;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            n_compared++;
            if (sb.size() == 0) begin
               n_mismatched++;
               $display("[TB] FAIL unexpected_result: got y=0x%0h, expected no result", y);
            end else begin
               e = sb.pop_front();
               if (y !== e.y || carry !== e.c || zero !== e.z || neg !== e.n ||
                   ovf !== e.v || illegal !== e.il) begin
                  n_mismatched++;
                  $display("[TB] FAIL %s: got y=0x%0h c=%b z=%b n=%b v=%b il=%b, expected y=0x%0h c=%b z=%b n=%b v=%b il=%b",
                           e.name, y, carry, zero, neg, ovf, illegal,
                           e.y, e.c, e.z, e.n, e.v, e.il);
               end
            end
         end
      end
   end

   task automatic mulTiming(input string nm);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checkOutput({nm, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      checkOutput({nm, "_out_valid_cycle9"}, {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin : stimulus
      n_compared   = 0;
      n_mismatched = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a = '0; b = '0; op = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_state", {24'd0, out_valid, y, carry, zero, neg, ovf, illegal, in_ready},
                  {24'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
      @(posedge clk);
      #1;

      // Carry chaining, borrow and signed overflow
      applyStimulus("add_carry", 4'd0, 8'hF0, 8'h20, 8'h10, 1, 0, 0, 0, 0);
      applyStimulus("adc_cf1",   4'd8, 8'h01, 8'h01, 8'h03, 0, 0, 0, 0, 0);
      applyStimulus("sub_borrow",4'd1, 8'h10, 8'h20, 8'hF0, 1, 0, 1, 0, 0);
      applyStimulus("sbb_cf1",   4'd9, 8'h05, 8'h01, 8'h03, 0, 0, 0, 0, 0);
      applyStimulus("add_ovf",   4'd0, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1, 0);
      applyStimulus("xor_zero",  4'd4, 8'h5A, 8'h5A, 8'h00, 0, 1, 0, 0, 0);

      // Multiply latency and product
      applyStimulus("mul_hi",    4'd13, 8'h12, 8'h10, 8'h20, 1, 0, 0, 0, 0);
      mulTiming("mul_hi");
      applyStimulus("mul_lo",    4'd13, 8'h0F, 8'h03, 8'h2D, 0, 0, 0, 0, 0);
      mulTiming("mul_lo");

      // Shifts, rotates, compare
      applyStimulus("rol",       4'd10, 8'h81, 8'h00, 8'h03, 1, 0, 0, 0, 0);
      applyStimulus("ror",       4'd11, 8'h81, 8'h00, 8'hC0, 1, 0, 1, 0, 0);
      applyStimulus("sra",       4'd12, 8'h81, 8'h00, 8'hC0, 1, 0, 1, 0, 0);
      applyStimulus("shr",       4'd7,  8'h81, 8'h00, 8'h40, 1, 0, 0, 0, 0);
      applyStimulus("cmp_eq",    4'd14, 8'h55, 8'h55, 8'h55, 0, 1, 0, 0, 0);
      applyStimulus("cmp_lt",    4'd14, 8'h10, 8'h20, 8'h10, 1, 0, 0, 0, 0);
      applyStimulus("not",       4'd5,  8'h0F, 8'h00, 8'hF0, 0, 0, 1, 0, 0);

      // Backpressure hold, then consume and accept in the same cycle
      applyStimulus("and_held",  4'd2, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 0);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("hold_y",        {24'd0, y}, 32'h30);
         checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
         checkOutput("hold_valid",    {31'd0, out_valid}, 32'd1);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      applyStimulus("or_replace", 4'd3, 8'h0F, 8'hF0, 8'hFF, 0, 0, 1, 0, 0);
      @(negedge clk);
      checkOutput("replace_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;

      // Reset aborts a multiply and clears cf
      applyStimulus("shl_cf1",   4'd6, 8'h80, 8'h00, 8'h00, 1, 1, 0, 0, 0);
      applyStimulus("mul_abort", 4'd13, 8'h03, 8'h03, 8'h09, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_state", {29'd0, out_valid, zero, in_ready}, {29'd0, 1'b0, 1'b1, 1'b1});
      @(posedge clk);
      #1;
      applyStimulus("adc_cf0",   4'd8,  8'h01, 8'h01, 8'h02, 0, 0, 0, 0, 0);
      applyStimulus("reserved",  4'd15, 8'hAA, 8'h55, 8'h00, 0, 1, 0, 0, 1);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      checkOutput("scoreboard_drained", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
